// File: rtl/dvp_source.sv
// OV5640-style DVP camera emulator: RGB565 valid/ready stream in, VSYNC/HREF/byte stream out.
// Optional macro DVP_SOURCE_TEST_PATTERN_EN adds a test_mode input driving an internal 8-bar colour generator.
module dvp_source #(
    parameter int H_PIXELS    = 1280,
    parameter int H_TOTAL     = 3300,
    parameter int V_ACTIVE    = 720,
    parameter int VS_LINES    = 4,
    parameter int V_BP        = 20,
    parameter int V_TOTAL     = 750,
    parameter int HCOUNT_BITS = 12,
    parameter int VCOUNT_BITS = 11
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        enable,
`ifdef DVP_SOURCE_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_frame_start,
    output logic        o_underflow
);

    localparam logic [HCOUNT_BITS-1:0] H_LAST = HCOUNT_BITS'(H_TOTAL - 1);
    localparam logic [VCOUNT_BITS-1:0] V_LAST = VCOUNT_BITS'(V_TOTAL - 1);
    localparam int ACT_BEG = VS_LINES + V_BP;
    localparam int ACT_END = VS_LINES + V_BP + V_ACTIVE;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nx;
    logic [HCOUNT_BITS-1:0] h_cnt, h_cnt_nx;
    logic [VCOUNT_BITS-1:0] v_cnt, v_cnt_nx;
    logic                   run, h_last, v_last;
    logic                   vs_c, act_line, href_c, slot, frame_start_c;
    logic [15:0]            px_data;
    logic                   px_valid;
    logic [7:0]             lo_byte;

    assign run           = (state == RUN);
    assign h_last        = (h_cnt == H_LAST);
    assign v_last        = (v_cnt == V_LAST);
    assign vs_c          = (int'(v_cnt) < VS_LINES);
    assign act_line      = (int'(v_cnt) >= ACT_BEG) && (int'(v_cnt) < ACT_END);
    assign href_c        = act_line && (int'(h_cnt) < 2 * H_PIXELS);
    assign slot          = run && href_c && !h_cnt[0];
    assign frame_start_c = run && (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        state_nx = state;
        h_cnt_nx = h_cnt;
        v_cnt_nx = v_cnt;
        case (state)
            IDLE: begin
                h_cnt_nx = '0;
                v_cnt_nx = '0;
                if (enable) state_nx = RUN;
            end
            RUN: begin
                if (h_last) begin
                    h_cnt_nx = '0;
                    if (v_last) begin
                        // enable only matters here, so a running frame is never cut short
                        v_cnt_nx = '0;
                        if (!enable) state_nx = IDLE;
                    end else begin
                        v_cnt_nx = v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt_nx = h_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef DVP_SOURCE_TEST_PATTERN_EN
    localparam int BAR_W = H_PIXELS / 8;

    logic       tp_on;
    logic [2:0] bar_idx;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    assign bar_idx = 3'((int'(h_cnt) / 2) / BAR_W);
    assign s_ready = slot && !tp_on;

    always_comb begin
        px_data  = s_data;
        px_valid = s_valid;
        if (tp_on) begin
            px_data  = bar_color(bar_idx);
            px_valid = 1'b1;
        end
    end

    // test_mode is latched only on edges that start a new frame
    always_ff @(posedge pixclk) begin
        if (reset) begin
            tp_on <= 1'b0;
        end else if (enable && ((state == IDLE) || (run && h_last && v_last))) begin
            tp_on <= test_mode;
        end
    end
`else
    assign s_ready  = slot;
    assign px_data  = s_data;
    assign px_valid = s_valid;
`endif

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state         <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_vsync       <= 1'b0;
            o_href        <= 1'b0;
            o_frame_start <= 1'b0;
            o_data        <= '0;
            o_underflow   <= 1'b0;
        end else begin
            state         <= state_nx;
            h_cnt         <= h_cnt_nx;
            v_cnt         <= v_cnt_nx;
            o_vsync       <= run && vs_c;
            o_href        <= run && href_c;
            o_frame_start <= frame_start_c;
            if (slot) begin
                o_data <= px_valid ? px_data[15:8] : 8'h00;
            end else if (run && href_c) begin
                o_data <= lo_byte;
            end else begin
                o_data <= '0;
            end
            // a missing pixel outranks the frame-start clear on the same edge
            if (!run) begin
                o_underflow <= 1'b0;
            end else if (slot && !px_valid) begin
                o_underflow <= 1'b1;
            end else if (frame_start_c) begin
                o_underflow <= 1'b0;
            end
        end
    end

    // low byte of the pixel in flight; a missing pixel sends zero for both bytes
    always_ff @(posedge pixclk) begin
        if (slot) lo_byte <= px_valid ? px_data[7:0] : 8'h00;
    end

endmodule

// File: tb/tb_dvp_source.sv
// Scoreboard bench for dvp_source: frame-level reference model feeds expected queues, a monitor pops and compares.
module tb_dvp_source;

    localparam int H_PIXELS = 4;
    localparam int H_TOTAL  = 12;
    localparam int V_ACTIVE = 3;
    localparam int VS_LINES = 1;
    localparam int V_BP     = 1;
    localparam int V_TOTAL  = 6;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int NPIX     = H_PIXELS * V_ACTIVE;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, o_vsync, o_href, o_frame_start, o_underflow;
    logic [7:0]  o_data;

    always #5 pixclk = ~pixclk;

    dvp_source #(
        .H_PIXELS(H_PIXELS), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .VS_LINES(VS_LINES), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .HCOUNT_BITS(4), .VCOUNT_BITS(3)
    ) dut (
        .pixclk(pixclk),
        .reset(reset),
        .enable(enable),
`ifdef DVP_SOURCE_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .o_vsync(o_vsync),
        .o_href(o_href),
        .o_data(o_data),
        .o_frame_start(o_frame_start),
        .o_underflow(o_underflow)
    );

    typedef struct packed {
        logic       vs;
        logic       href;
        logic       fs;
        logic       uf;
        logic [7:0] data;
    } exp_t;

    exp_t out_q[$];
    bit   rdy_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // reference model state: running flag, cycle position in frame, sticky underflow
    bit          m_run = 0;
    int          m_pos = 0;
    bit          m_uf  = 0;
    int          m_frame = 0;
    int          m_fs_total = 0;
    int          m_rdy_total = 0;
    logic [15:0] pix_data [NPIX];
    bit          pix_valid[NPIX];
    int          dut_fs = 0;
    int          dut_rdy = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic gen_frame();
        for (int k = 0; k < NPIX; k++) begin
            if (m_frame == 0) begin
                pix_data[k]  = 16'hA1B2 + 16'(k) * 16'h2222;
                pix_valid[k] = 1;
            end else begin
                pix_data[k]  = 16'($urandom);
                pix_valid[k] = (m_frame == 1) ? (k != 1) : ($urandom_range(0, 5) != 0);
            end
        end
        m_frame++;
    endtask

    task automatic step(input bit rst_i, input bit en_i);
        int   line, col, k;
        bit   hr, slot;
        exp_t e;
        @(negedge pixclk);
        #1;
        reset  = rst_i;
        enable = en_i;
        if (m_run && m_pos == 0) gen_frame();
        line = m_pos / H_TOTAL;
        col  = m_pos % H_TOTAL;
        hr   = m_run && line >= VS_LINES + V_BP && line < VS_LINES + V_BP + V_ACTIVE
               && col < 2 * H_PIXELS;
        slot = hr && (col % 2 == 0);
        k    = hr ? (line - VS_LINES - V_BP) * H_PIXELS + col / 2 : 0;
        if (slot) begin
            s_valid = pix_valid[k];
            s_data  = pix_data[k];
        end else begin
            s_valid = 1'($urandom);
            s_data  = 16'($urandom);
        end
        rdy_q.push_back(slot);
        if (slot) m_rdy_total++;
        e = '0;
        if (rst_i) begin
            m_run = 0;
            m_pos = 0;
            m_uf  = 0;
        end else if (!m_run) begin
            m_uf = 0;
            if (en_i) begin
                m_run = 1;
                m_pos = 0;
            end
        end else begin
            e.vs   = (line < VS_LINES);
            e.href = hr;
            e.fs   = (m_pos == 0);
            if (e.fs) begin
                m_uf = 0;
                m_fs_total++;
            end
            if (hr) begin
                if (!pix_valid[k]) begin
                    e.data = 8'h00;
                    if (slot) m_uf = 1;
                end else begin
                    e.data = slot ? pix_data[k][15:8] : pix_data[k][7:0];
                end
            end
            e.uf = m_uf;
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                if (!en_i) m_run = 0;
            end
        end
        out_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        bit   r;
        forever begin
            @(negedge pixclk);
            #2;
            if (s_ready === 1'b1) dut_rdy++;
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                chk("s_ready", 16'(s_ready), 16'(r));
            end
            @(posedge pixclk);
            #1;
            if (o_frame_start === 1'b1) dut_fs++;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("o_vsync", 16'(o_vsync), 16'(e.vs));
                chk("o_href", 16'(o_href), 16'(e.href));
                chk("o_frame_start", 16'(o_frame_start), 16'(e.fs));
                chk("o_underflow", 16'(o_underflow), 16'(e.uf));
                chk("o_data", 16'(o_data), 16'(e.data));
            end
        end
    end

    initial begin
        repeat (3) step(1, 0);
        repeat (2) step(0, 0);
        // three back-to-back frames: ordered bytes, one missing pixel, random gaps
        step(0, 1);
        repeat (3 * FRAME) step(0, 1);
        // enable dropped mid-frame: frame must run to its end, then idle
        repeat (30) step(0, 1);
        repeat (FRAME - 30) step(0, 0);
        repeat (5) step(0, 0);
        // restart, then reset in the middle of an active line
        step(0, 1);
        repeat (27) step(0, 1);
        step(1, 1);
        step(1, 0);
        repeat (3) step(0, 0);
        // one more run after reset
        step(0, 1);
        repeat (FRAME + 5) step(0, 1);
        repeat (FRAME + 4) step(0, 0);
        repeat (3) @(posedge pixclk);
        #3;
        chk("frame_start_count", 16'(dut_fs), 16'(m_fs_total));
        chk("s_ready_count", 16'(dut_rdy), 16'(m_rdy_total));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
